// File: rtl/pin_id_uart_tx_if.sv
// Pin-ID UART transmitter bus: enable request plus the per-pin serial lines
// and status flags. The master side is the requester; the slave side is the
// transmitter.
interface pin_id_uart_tx_if #(
  parameter int NUM_PINS = 162
) ();
  logic                enable;
  logic [NUM_PINS-1:0] pins_out;
  logic                busy;
  logic                msg_start;

  modport master (output enable, input pins_out, input busy, input msg_start);
  modport slave  (input enable, output pins_out, output busy, output msg_start);
endinterface

// File: rtl/pin_id_uart_tx.sv
// Pin-ID UART transmitter: every pin i repeatedly sends "P<hex i>\r\n" as
// 8N1 frames. All pins share one baud/bit/char sequencer and start together;
// only the character contents differ per pin.
// Optional feature: define PIN_ID_UART_TX_PARITY_EN for 8E1 frames.
//
// state  | meaning
// IDLE   | lines high, waiting for enable
// START  | start bit (0)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (parity build only)
// STOP   | stop bit (1)
// GAP    | GAP_BITS idle bit-times after LF
module pin_id_uart_tx #(
  parameter int NUM_PINS = 162,
  parameter int CLK_HZ   = 25000000,
  parameter int BAUD     = 115200,
  parameter int GAP_BITS = 10
) (
  input  logic             clk25,
  input  logic             rst_,
  pin_id_uart_tx_if.slave  bus
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] DIV_M1 = BW'(DIV - 1);
  localparam logic [7:0]    GAP_M1 = 8'(GAP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  state_t              state, state_d;
  logic [BW-1:0]       baud_cnt, baud_d;
  logic [7:0]          bit_cnt, bit_d;   // data bit index, reused as gap bit count
  logic [2:0]          char_idx, char_d;
  logic                msg_start_q, msg_start_d;
  logic [NUM_PINS-1:0] pins_q, line_d;
  logic [7:0]          ch;
  logic                tc;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] msg_char(input logic [2:0] idx, input logic [7:0] pin);
    case (idx)
      3'd0:    return 8'h50;
      3'd1:    return hex_ascii(pin[7:4]);
      3'd2:    return hex_ascii(pin[3:0]);
      3'd3:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  assign tc            = (baud_cnt == '0);
  assign bus.busy      = (state != IDLE);
  assign bus.msg_start = msg_start_q;
  assign bus.pins_out  = pins_q;

  // State, counters and the registered line drivers.
  always_ff @(posedge clk25 or negedge rst_) begin
    if (!rst_) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      char_idx    <= '0;
      msg_start_q <= 1'b0;
      pins_q      <= '1;
    end else begin
      state       <= state_d;
      baud_cnt    <= baud_d;
      bit_cnt     <= bit_d;
      char_idx    <= char_d;
      msg_start_q <= msg_start_d;
      pins_q      <= line_d;
    end
  end

  // Next state and counter values; every bit lasts DIV cycles (baud down-counter to 0).
  always_comb begin
    state_d     = state;
    baud_d      = baud_cnt - BW'(1);
    bit_d       = bit_cnt;
    char_d      = char_idx;
    msg_start_d = 1'b0;
    case (state)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        char_d = '0;
        if (bus.enable) begin
          state_d     = START;
          baud_d      = DIV_M1;
          msg_start_d = 1'b1;
        end
      end
      START: begin
        if (tc) begin
          state_d = DATA;
          bit_d   = '0;
          baud_d  = DIV_M1;
        end
      end
      DATA: begin
        if (tc) begin
          baud_d = DIV_M1;
          if (bit_cnt == 8'd7) begin
`ifdef PIN_ID_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_cnt + 8'd1;
          end
        end
      end
      PARITY: begin
        if (tc) begin
          state_d = STOP;
          baud_d  = DIV_M1;
        end
      end
      STOP: begin
        if (tc) begin
          baud_d = DIV_M1;
          if (char_idx == 3'd4) begin
            state_d = GAP;
            bit_d   = '0;
          end else begin
            state_d = START;
            char_d  = char_idx + 3'd1;
          end
        end
      end
      GAP: begin
        if (tc) begin
          baud_d = DIV_M1;
          if (bit_cnt == GAP_M1) begin
            // enable is only looked at here, so a dropped enable never cuts a message short
            if (bus.enable) begin
              state_d     = START;
              char_d      = '0;
              msg_start_d = 1'b1;
            end else begin
              state_d = IDLE;
              baud_d  = '0;
            end
          end else begin
            bit_d = bit_cnt + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level each pin will carry in the next state, registered into pins_q.
  always_comb begin
    line_d = '1;
    ch     = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      ch = msg_char(char_d, 8'(i));
      case (state_d)
        START:   line_d[i] = 1'b0;
        DATA:    line_d[i] = ch[bit_d[2:0]];
        PARITY:  line_d[i] = ^ch;
        default: line_d[i] = 1'b1;
      endcase
    end
  end
endmodule
